// File: rtl/axi_pkg.sv
// Shared definitions for the simplified 64-bit AXI-lite-style memory channels:
// channel widths, the read/write FSM state types and an address-window helper.
package axi_pkg;

    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = 8;

    // Service latency counters cover wait counts 0..15.
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        WIDLE,
        WWAIT,
        WRESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RIDLE,
        RWAIT,
        RRESP
    } rd_state_t;

    // True when addr falls in [base, base+span). Subtracting first keeps the
    // upper bound from overflowing when the window sits at the top of memory.
    function automatic logic in_window(
        input logic [AXI_ADDR_W-1:0] addr,
        input logic [AXI_ADDR_W-1:0] base,
        input logic [AXI_ADDR_W-1:0] span
    );
        logic [AXI_ADDR_W-1:0] rel;
        rel = addr - base;
        return (addr >= base) && (rel < span);
    endfunction

endpackage

// File: rtl/sram_dw_array.sv
// Doubleword storage array: one synchronous write port with per-byte enables
// and one asynchronous read port. Contents are never reset.
module sram_dw_array
    import axi_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wbe,
    input  logic [IDX_W-1:0]      raddr,
    output logic [AXI_DATA_W-1:0] rdata
);

    logic [AXI_DATA_W-1:0] mem [DEPTH];

    // Byte-masked write; only enabled lanes of the addressed entry change.
    // NOTE: the array has no reset branch on purpose -- contents must survive
    // rst_n, and a reset loop over every entry would stop it mapping to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < AXI_STRB_W; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Asynchronous read: a same-cycle write is not yet visible here, so a
    // read sampled on the commit edge returns the pre-write contents.
    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sram_responder.sv
// AXI-lite-style slave memory answering the core's load/store master.
// Independent write (AW/W/B) and read (AR/R) FSMs, each with a fixed service
// latency, front a doubleword array. Data on W/R is address-relative: byte 0
// of the bus is the byte at the request address, so the top shifts lanes by
// addr[2:0] and drops any bytes that would cross into the next doubleword.
module axi_sram_responder
    import axi_pkg::*;
#(
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = 64'h8000_0000,
    parameter int                    DEPTH_DW   = 4096,
    parameter int                    RD_LATENCY = 1,
    parameter int                    WR_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [AXI_ADDR_W-1:0] AW_ADDR,
    input  logic                  AW_VALID,
    output logic                  AW_READY,

    input  logic [AXI_DATA_W-1:0] W_DATA,
    input  logic [AXI_STRB_W-1:0] W_STRB,
    input  logic                  W_VALID,
    output logic                  W_READY,

    output logic                  B_VALID,
    input  logic                  B_READY,

    input  logic [AXI_ADDR_W-1:0] AR_ADDR,
    input  logic                  AR_VALID,
    output logic                  AR_READY,

    output logic [AXI_DATA_W-1:0] R_DATA,
    output logic                  R_VALID,
    input  logic                  R_READY,

    output logic                  err_addr
);

    localparam int                    IDX_W      = $clog2(DEPTH_DW);
    localparam logic [AXI_ADDR_W-1:0] SPAN_BYTES = AXI_ADDR_W'(DEPTH_DW) << 3;
    localparam logic [LAT_W-1:0]      RD_LAT     = LAT_W'(RD_LATENCY);
    localparam logic [LAT_W-1:0]      WR_LAT     = LAT_W'(WR_LATENCY);

    // ------------------------------------------------------------------
    // Write-side state
    // ------------------------------------------------------------------
    wr_state_t             wr_state;
    logic [LAT_W-1:0]      wr_cnt;
    logic                  aw_ready_q;
    logic                  w_ready_q;
    logic                  b_valid_q;
    logic [AXI_ADDR_W-1:0] aw_addr_q;
    logic [AXI_DATA_W-1:0] w_data_q;
    logic [AXI_STRB_W-1:0] w_strb_q;

    // ------------------------------------------------------------------
    // Read-side state
    // ------------------------------------------------------------------
    rd_state_t             rd_state;
    logic [LAT_W-1:0]      rd_cnt;
    logic                  ar_ready_q;
    logic                  r_valid_q;
    logic [AXI_DATA_W-1:0] r_data_q;
    logic [AXI_ADDR_W-1:0] ar_addr_q;

    logic                  err_q;

    // ------------------------------------------------------------------
    // Address decode, lane alignment and array hookup
    // ------------------------------------------------------------------
    logic [AXI_ADDR_W-1:0] wr_rel;
    logic [AXI_ADDR_W-1:0] rd_rel;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  mem_we;
    logic [AXI_DATA_W-1:0] wr_data_sh;
    logic [AXI_STRB_W-1:0] wr_be_sh;
    logic [AXI_DATA_W-1:0] mem_rdata;
    logic [AXI_DATA_W-1:0] rd_lane;

    assign wr_rel = aw_addr_q - BASE_ADDR;
    assign rd_rel = ar_addr_q - BASE_ADDR;
    assign wr_ok  = in_window(aw_addr_q, BASE_ADDR, SPAN_BYTES);
    assign rd_ok  = in_window(ar_addr_q, BASE_ADDR, SPAN_BYTES);

    // Handshakes use the registered READYs, so READY never depends on VALID.
    assign aw_hs = (wr_state == WIDLE) && AW_VALID && aw_ready_q;
    assign w_hs  = (wr_state == WIDLE) && W_VALID  && w_ready_q;

    // The cycle in which a wait count has run out is the commit/sample cycle.
    assign wr_fire = (wr_state == WWAIT) && (wr_cnt == '0);
    assign rd_fire = (rd_state == RWAIT) && (rd_cnt == '0);
    assign mem_we  = wr_fire && wr_ok;

    // Shifting within the bus width discards lanes past byte 7.
    assign wr_data_sh = w_data_q << {aw_addr_q[2:0], 3'b000};
    assign wr_be_sh   = w_strb_q << aw_addr_q[2:0];

    sram_dw_array #(
        .DEPTH (DEPTH_DW),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_rel[IDX_W+2:3]),
        .wdata (wr_data_sh),
        .wbe   (wr_be_sh),
        .raddr (rd_rel[IDX_W+2:3]),
        .rdata (mem_rdata)
    );

    // Read lane extraction: entry shifted down by the byte offset, zero-filled;
    // out-of-range reads return zero.
    // NOTE: every always_comb output gets a default first so that no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rd_lane = '0;
        if (rd_ok) begin
            rd_lane = mem_rdata >> {ar_addr_q[2:0], 3'b000};
        end
    end

    // Write FSM: collect AW and W in any order, wait WR_LATENCY, commit, respond.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state   <= WIDLE;
            wr_cnt     <= '0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            b_valid_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            case (wr_state)
                WIDLE: begin
                    if (aw_hs) begin
                        aw_addr_q  <= AW_ADDR;
                        aw_ready_q <= 1'b0;
                    end
                    if (w_hs) begin
                        w_data_q  <= W_DATA;
                        w_strb_q  <= W_STRB;
                        w_ready_q <= 1'b0;
                    end
                    // A dropped READY means that channel was already captured.
                    if ((aw_hs || !aw_ready_q) && (w_hs || !w_ready_q)) begin
                        wr_state <= WWAIT;
                        wr_cnt   <= WR_LAT;
                    end
                end
                WWAIT: begin
                    if (wr_cnt == '0) begin
                        wr_state  <= WRESP;
                        b_valid_q <= 1'b1;
                    end else begin
                        wr_cnt <= wr_cnt - 1'b1;
                    end
                end
                WRESP: begin
                    if (B_READY) begin
                        wr_state   <= WIDLE;
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    wr_state <= WIDLE;
                end
            endcase
        end
    end

    // Read FSM: capture AR, wait RD_LATENCY, sample the array, hold R until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state   <= RIDLE;
            rd_cnt     <= '0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            ar_addr_q  <= '0;
        end else begin
            case (rd_state)
                RIDLE: begin
                    if (AR_VALID && ar_ready_q) begin
                        ar_addr_q  <= AR_ADDR;
                        ar_ready_q <= 1'b0;
                        rd_cnt     <= RD_LAT;
                        rd_state   <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (rd_cnt == '0) begin
                        r_data_q  <= rd_lane;
                        r_valid_q <= 1'b1;
                        rd_state  <= RRESP;
                    end else begin
                        rd_cnt <= rd_cnt - 1'b1;
                    end
                end
                RRESP: begin
                    if (R_READY) begin
                        r_valid_q  <= 1'b0;
                        r_data_q   <= '0;
                        ar_ready_q <= 1'b1;
                        rd_state   <= RIDLE;
                    end
                end
                default: begin
                    rd_state <= RIDLE;
                end
            endcase
        end
    end

    // Sticky address error, raised when either side services an out-of-range access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((wr_fire && !wr_ok) || (rd_fire && !rd_ok)) begin
            err_q <= 1'b1;
        end
    end

    assign AW_READY = aw_ready_q;
    assign W_READY  = w_ready_q;
    assign B_VALID  = b_valid_q;
    assign AR_READY = ar_ready_q;
    assign R_VALID  = r_valid_q;
    assign R_DATA   = r_data_q;
    assign err_addr = err_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: a vector table of writes/reads with
// hand-computed results, plus hand-written multi-cycle sequences for channel
// ordering, response back-pressure, same-cycle commit/read and mid-write reset.
module tb_axi_sram_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Default-latency instance
    logic [63:0] aw_addr = '0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [63:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [63:0] r_data;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic        err_addr;

    // Zero read latency instance
    logic [63:0] z_aw_addr = '0;
    logic        z_aw_valid = 1'b0;
    logic        z_aw_ready;
    logic [63:0] z_w_data = '0;
    logic [7:0]  z_w_strb = '0;
    logic        z_w_valid = 1'b0;
    logic        z_w_ready;
    logic        z_b_valid;
    logic        z_b_ready = 1'b0;
    logic [63:0] z_ar_addr = '0;
    logic        z_ar_valid = 1'b0;
    logic        z_ar_ready;
    logic [63:0] z_r_data;
    logic        z_r_valid;
    logic        z_r_ready = 1'b0;
    logic        z_err_addr;

    axi_sram_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .AW_ADDR  (aw_addr),
        .AW_VALID (aw_valid),
        .AW_READY (aw_ready),
        .W_DATA   (w_data),
        .W_STRB   (w_strb),
        .W_VALID  (w_valid),
        .W_READY  (w_ready),
        .B_VALID  (b_valid),
        .B_READY  (b_ready),
        .AR_ADDR  (ar_addr),
        .AR_VALID (ar_valid),
        .AR_READY (ar_ready),
        .R_DATA   (r_data),
        .R_VALID  (r_valid),
        .R_READY  (r_ready),
        .err_addr (err_addr)
    );

    axi_sram_responder #(.RD_LATENCY(0)) dut_z (
        .clk      (clk),
        .rst_n    (rst_n),
        .AW_ADDR  (z_aw_addr),
        .AW_VALID (z_aw_valid),
        .AW_READY (z_aw_ready),
        .W_DATA   (z_w_data),
        .W_STRB   (z_w_strb),
        .W_VALID  (z_w_valid),
        .W_READY  (z_w_ready),
        .B_VALID  (z_b_valid),
        .B_READY  (z_b_ready),
        .AR_ADDR  (z_ar_addr),
        .AR_VALID (z_ar_valid),
        .AR_READY (z_ar_ready),
        .R_DATA   (z_r_data),
        .R_VALID  (z_r_valid),
        .R_READY  (z_r_ready),
        .err_addr (z_err_addr)
    );

    typedef struct {
        bit          is_wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [63:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input bit is_wr, input logic [63:0] addr, input logic [63:0] data,
                                input logic [7:0] strb, input logic [63:0] exp_data, input bit exp_err);
        vec_t v;
        v.is_wr = is_wr; v.addr = addr; v.data = data; v.strb = strb;
        v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    // Full write transaction; lat = edges from the later handshake to B_VALID, -1 on timeout.
    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            output int lat);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_addr = a; w_data = d; w_strb = s;
        aw_valid = 1'b1; w_valid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = aw_valid && aw_ready;
            w_hs  = w_valid && w_ready;
            tick(); n++;
            if (aw_hs) begin aw_done = 1'b1; aw_valid = 1'b0; end
            if (w_hs)  begin w_done = 1'b1;  w_valid = 1'b0; end
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        lat = 0;
        if (!(aw_done && w_done)) begin
            lat = -1;
            return;
        end
        while (!b_valid && lat < 40) begin tick(); lat++; end
        if (!b_valid) begin
            lat = -1;
            return;
        end
        b_ready = 1'b1; tick(); b_ready = 1'b0;
    endtask

    // Full read transaction; lat = edges from the AR handshake to R_VALID, -1 on timeout.
    task automatic do_read(input logic [63:0] a, output logic [63:0] data, output int lat);
        int n;
        ar_addr = a; ar_valid = 1'b1; n = 0; data = '0;
        while (!ar_ready && n < 20) begin tick(); n++; end
        if (!ar_ready) begin
            ar_valid = 1'b0; lat = -1;
            return;
        end
        tick(); ar_valid = 1'b0; lat = 0;
        while (!r_valid && lat < 40) begin tick(); lat++; end
        if (!r_valid) begin
            lat = -1;
            return;
        end
        data = r_data;
        r_ready = 1'b1; tick(); r_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        int          lat;
        int          n;

        // Entry 0x10 = 1122334455667788; byte 3 then bytes 6..7 patched.
        vecs.push_back(mk(1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, '0, 0));
        vecs.push_back(mk(0, 64'h8000_0010, '0, '0, 64'h1122_3344_5566_7788, 0));
        vecs.push_back(mk(1, 64'h8000_0013, 64'h0000_0000_0000_00AB, 8'h01, '0, 0));
        vecs.push_back(mk(0, 64'h8000_0010, '0, '0, 64'h1122_3344_AB66_7788, 0));
        vecs.push_back(mk(0, 64'h8000_0013, '0, '0, 64'h0000_0011_2233_44AB, 0));
        vecs.push_back(mk(1, 64'h8000_0000, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, '0, 0));
        // Offset 6: only bus bytes 0,1 (22,33) land; the rest cross the boundary.
        vecs.push_back(mk(1, 64'h8000_0016, 64'h9988_7766_5544_3322, 8'hFF, '0, 0));
        vecs.push_back(mk(0, 64'h8000_0010, '0, '0, 64'h3322_3344_AB66_7788, 0));
        // Last in-range entry.
        vecs.push_back(mk(1, 64'h8000_7FF8, 64'h0102_0304_0506_0708, 8'hFF, '0, 0));
        vecs.push_back(mk(0, 64'h8000_7FF8, '0, '0, 64'h0102_0304_0506_0708, 0));
        // Out of range below and above; the error stays set.
        vecs.push_back(mk(0, 64'h7FFF_FFF8, '0, '0, 64'h0, 1));
        vecs.push_back(mk(1, 64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, '0, 1));
        vecs.push_back(mk(0, 64'h8000_0000, '0, '0, 64'hCAFE_F00D_DEAD_BEEF, 1));

        // Reset state
        repeat (3) tick();
        check("rst_aw_ready", 64'(aw_ready), 64'd1);
        check("rst_w_ready",  64'(w_ready),  64'd1);
        check("rst_ar_ready", 64'(ar_ready), 64'd1);
        check("rst_b_valid",  64'(b_valid),  64'd0);
        check("rst_r_valid",  64'(r_valid),  64'd0);
        check("rst_r_data",   r_data,        64'd0);
        check("rst_err",      64'(err_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, lat);
                check($sformatf("v%0d_wr_lat", i), 64'(lat), 64'd2);
            end else begin
                do_read(vecs[i].addr, rd, lat);
                check($sformatf("v%0d_rd_lat", i), 64'(lat), 64'd2);
                check($sformatf("v%0d_rd_data", i), rd, vecs[i].exp_data);
            end
            check($sformatf("v%0d_err", i), 64'(err_addr), 64'(vecs[i].exp_err));
        end
        check("r_data_cleared", r_data, 64'd0);

        // W three cycles ahead of AW, then B held off for four cycles
        w_data = 64'h0F1E_2D3C_4B5A_6978; w_strb = 8'hFF; w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        check("wfirst_w_ready",  64'(w_ready),  64'd0);
        check("wfirst_aw_ready", 64'(aw_ready), 64'd1);
        tick(); tick();
        check("wfirst_no_b", 64'(b_valid), 64'd0);
        aw_addr = 64'h8000_0020; aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0;
        check("wfirst_aw_dropped", 64'(aw_ready), 64'd0);
        tick();
        check("wfirst_b_early", 64'(b_valid), 64'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bhold%0d_b_valid", k),  64'(b_valid),  64'd1);
            check($sformatf("bhold%0d_aw_ready", k), 64'(aw_ready), 64'd0);
            check($sformatf("bhold%0d_w_ready", k),  64'(w_ready),  64'd0);
            tick();
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check("bdone_aw_ready", 64'(aw_ready), 64'd1);
        check("bdone_w_ready",  64'(w_ready),  64'd1);
        check("bdone_b_valid",  64'(b_valid),  64'd0);
        do_read(64'h8000_0020, rd, lat);
        check("wfirst_readback", rd, 64'h0F1E_2D3C_4B5A_6978);

        // Zero read latency: commit and sample to the same entry on one edge
        z_aw_addr = 64'h8000_0040; z_w_data = 64'h0A0A_0A0A_0A0A_0A0A; z_w_strb = 8'hFF;
        z_aw_valid = 1'b1; z_w_valid = 1'b1;
        tick();
        z_aw_valid = 1'b0; z_w_valid = 1'b0;
        n = 0;
        while (!z_b_valid && n < 10) begin tick(); n++; end
        check("z_old_b_valid", 64'(z_b_valid), 64'd1);
        z_b_ready = 1'b1; tick(); z_b_ready = 1'b0;
        z_w_data = 64'h5B5B_5B5B_5B5B_5B5B;
        z_aw_valid = 1'b1; z_w_valid = 1'b1;
        tick();
        z_aw_valid = 1'b0; z_w_valid = 1'b0;
        z_ar_addr = 64'h8000_0040; z_ar_valid = 1'b1;
        tick();
        z_ar_valid = 1'b0;
        tick();
        check("z_same_r_valid", 64'(z_r_valid), 64'd1);
        check("z_same_b_valid", 64'(z_b_valid), 64'd1);
        check("z_same_old_data", z_r_data, 64'h0A0A_0A0A_0A0A_0A0A);
        z_r_ready = 1'b1; z_b_ready = 1'b1;
        tick();
        z_r_ready = 1'b0; z_b_ready = 1'b0;
        z_ar_valid = 1'b1;
        tick();
        z_ar_valid = 1'b0;
        tick();
        check("z_next_r_valid", 64'(z_r_valid), 64'd1);
        check("z_next_new_data", z_r_data, 64'h5B5B_5B5B_5B5B_5B5B);
        z_r_ready = 1'b1; tick(); z_r_ready = 1'b0;

        // Reset while the write waits: no commit, no response, data kept
        aw_addr = 64'h8000_0010; w_data = 64'hFFFF_FFFF_FFFF_FFFF; w_strb = 8'hFF;
        aw_valid = 1'b1; w_valid = 1'b1;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("mrst_aw_ready", 64'(aw_ready), 64'd1);
        check("mrst_w_ready",  64'(w_ready),  64'd1);
        check("mrst_ar_ready", 64'(ar_ready), 64'd1);
        check("mrst_r_data",   r_data,        64'd0);
        check("mrst_err",      64'(err_addr), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mrst_no_b%0d", k), 64'(b_valid), 64'd0);
            tick();
        end
        do_read(64'h8000_0010, rd, lat);
        check("mrst_entry_kept", rd, 64'h3322_3344_AB66_7788);
        do_read(64'h8000_0020, rd, lat);
        check("mrst_other_kept", rd, 64'h0F1E_2D3C_4B5A_6978);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
